// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package memory_stage_pkg;

    localparam int unsigned ADDR_W_DEF = 11;

    function automatic int unsigned sp_top(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    localparam int unsigned SP_INIT_DEF = sp_top(ADDR_W_DEF);

    typedef enum logic [1:0] {
        ADDR_RESULT = 2'b00,
        ADDR_SP     = 2'b01,
        ADDR_RDEST  = 2'b10
    } addr_sel_e;

    typedef enum logic [1:0] {
        WSRC_RDEST = 2'b00,
        WSRC_RSRC  = 2'b01,
        WSRC_PC1   = 2'b10,
        WSRC_PC    = 2'b11
    } wsrc_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WORD2 = 1'b1
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [2:0] reg_write_address;
        logic       outport_enable;
    } wb_ctrl_t;

endpackage

// File: rtl/memory_stage_data_memory.sv
// 2**ADDR_W x 16 data memory: synchronous write, combinational read.
module data_memory #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: load/store, stack push/pop, two-cycle 32-bit PC push/pop.
// Optional macro STACK_GUARD_EN adds stack overflow/underflow protection and stack_fault_out.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned SP_INIT = sp_top(ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       result,
    input  logic [15:0]       read_data1,
    input  logic [15:0]       read_data2,
    input  logic [31:0]       pc_plus_one,
    input  logic [31:0]       PC,
    input  logic [15:0]       LDM_value,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic [1:0]        memory_address_select,
    input  logic [1:0]        memory_write_src_select,
    input  logic              pc_choose_memory,
    input  logic              reg_write,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        reg_write_address,
    input  logic              outport_enable,
    output logic              stall_out,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       result_out,
    output logic [15:0]       LDM_value_out,
    output logic              reg_write_out,
    output logic [1:0]        wb_sel_out,
    output logic [2:0]        reg_write_address_out,
    output logic              outport_enable_out,
    output logic [31:0]       new_pc_out,
    output logic              pc_load_out,
`ifdef STACK_GUARD_EN
    output logic              stack_fault_out,
`endif
    output logic [ADDR_W-1:0] sp_out
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       hold_q, hold_d;
    logic              w2_pop_q, w2_pop_d;
    logic [15:0]       mem_data_q, mem_data_d;
    logic [15:0]       result_q, ldm_q;
    wb_ctrl_t          ctrl_in, ctrl_q, ctrl_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic              pc_load_q, pc_load_d;

    logic              push_op, pop_op, both_op, push32, pop32, guard_c;
    logic [ADDR_W-1:0] sp_plus, sp_minus, plain_addr, mem_addr;
    logic [31:0]       src32;
    logic [15:0]       wdata16, mem_wdata, mem_rdata;
    logic              mem_we;

    assign ctrl_in  = wb_ctrl_t'{reg_write, wb_sel, reg_write_address, outport_enable};
    assign push_op  = mem_push & ~mem_pop;
    assign pop_op   = mem_pop & ~mem_push;
    assign both_op  = mem_push & mem_pop;
    assign push32   = push_op & memory_write_src_select[1];
    assign pop32    = pop_op & pc_choose_memory;
    assign sp_plus  = sp_q + ADDR_W'(1);
    assign sp_minus = sp_q - ADDR_W'(1);
    assign src32    = (memory_write_src_select == WSRC_PC) ? PC : pc_plus_one;

`ifdef STACK_GUARD_EN
    logic st_push_c, st_pop_c, fault_q;
    // In WORD2 the operation kind comes from the latched first cycle.
    assign st_push_c = (state_q == ST_WORD2) ? ~w2_pop_q : push_op;
    assign st_pop_c  = (state_q == ST_WORD2) ?  w2_pop_q : pop_op;
    assign guard_c   = (st_push_c & (sp_q == '0)) |
                       (st_pop_c  & (sp_q == ADDR_W'(SP_INIT)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       fault_q <= 1'b0;
        else if (guard_c) fault_q <= 1'b1;
    end
    assign stack_fault_out = fault_q;
`else
    assign guard_c = 1'b0;
`endif

    always_comb begin
        case (memory_address_select)
            ADDR_SP:    plain_addr = sp_q;
            ADDR_RDEST: plain_addr = read_data1[ADDR_W-1:0];
            default:    plain_addr = result[ADDR_W-1:0];
        endcase
        case (memory_write_src_select)
            WSRC_RDEST: wdata16 = read_data1;
            WSRC_RSRC:  wdata16 = read_data2;
            WSRC_PC1:   wdata16 = pc_plus_one[15:0];
            default:    wdata16 = PC[15:0];
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if ((push32 | pop32) && !guard_c) state_d = ST_WORD2;
            ST_WORD2: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, memory access and MEM/WB next values
    always_comb begin
        sp_d       = sp_q;
        hold_d     = hold_q;
        w2_pop_d   = w2_pop_q;
        mem_we     = 1'b0;
        mem_addr   = plain_addr;
        mem_wdata  = wdata16;
        mem_data_d = '0;
        ctrl_d     = ctrl_in;
        new_pc_d   = new_pc_q;
        pc_load_d  = 1'b0;
        stall_out  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (guard_c) begin
                    ctrl_d.reg_write      = 1'b0;
                    ctrl_d.outport_enable = 1'b0;
                end else if (push_op) begin
                    mem_addr = sp_q;
                    mem_we   = 1'b1;
                    sp_d     = sp_minus;
                    if (push32) begin
                        mem_wdata             = src32[31:16];
                        hold_d                = src32[15:0];
                        w2_pop_d              = 1'b0;
                        stall_out             = 1'b1;
                        ctrl_d.reg_write      = 1'b0;
                        ctrl_d.outport_enable = 1'b0;
                    end
                end else if (pop_op) begin
                    mem_addr   = sp_plus;
                    sp_d       = sp_plus;
                    mem_data_d = mem_rdata;
                    if (pop32) begin
                        hold_d                = mem_rdata;
                        w2_pop_d              = 1'b1;
                        stall_out             = 1'b1;
                        ctrl_d.reg_write      = 1'b0;
                        ctrl_d.outport_enable = 1'b0;
                    end
                end else if (both_op) begin
                    mem_we = 1'b0;
                end else if (mem_write) begin
                    mem_we = 1'b1;
                end else if (mem_read) begin
                    mem_data_d = mem_rdata;
                end
            end
            ST_WORD2: begin
                if (guard_c) begin
                    ctrl_d.reg_write      = 1'b0;
                    ctrl_d.outport_enable = 1'b0;
                end else if (w2_pop_q) begin
                    mem_addr   = sp_plus;
                    sp_d       = sp_plus;
                    mem_data_d = mem_rdata;
                    new_pc_d   = {mem_rdata, hold_q};
                    pc_load_d  = 1'b1;
                end else begin
                    mem_addr  = sp_q;
                    mem_we    = 1'b1;
                    mem_wdata = hold_q;
                    sp_d      = sp_minus;
                end
            end
        endcase
    end

    // MEM/WB buffer and stack pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q       <= ADDR_W'(SP_INIT);
            hold_q     <= '0;
            w2_pop_q   <= 1'b0;
            mem_data_q <= '0;
            result_q   <= '0;
            ldm_q      <= '0;
            ctrl_q     <= '0;
            new_pc_q   <= '0;
            pc_load_q  <= 1'b0;
        end else begin
            sp_q       <= sp_d;
            hold_q     <= hold_d;
            w2_pop_q   <= w2_pop_d;
            mem_data_q <= mem_data_d;
            result_q   <= result;
            ldm_q      <= LDM_value;
            ctrl_q     <= ctrl_d;
            new_pc_q   <= new_pc_d;
            pc_load_q  <= pc_load_d;
        end
    end

    // Writes are blocked while reset is held so an abandoned second word never lands.
    data_memory #(.ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .we    (mem_we & reset),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign mem_data_out          = mem_data_q;
    assign result_out            = result_q;
    assign LDM_value_out         = ldm_q;
    assign reg_write_out         = ctrl_q.reg_write;
    assign wb_sel_out            = ctrl_q.wb_sel;
    assign reg_write_address_out = ctrl_q.reg_write_address;
    assign outport_enable_out    = ctrl_q.outport_enable;
    assign new_pc_out            = new_pc_q;
    assign pc_load_out           = pc_load_q;
    assign sp_out                = sp_q;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table plus CALL/RET/reset sequences.
module tb_memory_stage;
    import memory_stage_pkg::*;

    typedef struct {
        logic [15:0] res, rd1, rd2;
        logic        rd, wr, push, pop;
        logic [1:0]  asel, wsrc;
        logic        rw;
        logic [15:0] e_data;
        logic [10:0] e_sp;
    } vec_t;

    typedef struct {
        logic [15:0] data, res, ldm;
        logic [10:0] sp;
        logic        rw, op, pc_load;
        logic [1:0]  wb;
        logic [2:0]  rwa;
        logic [31:0] new_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result, read_data1, read_data2, LDM_value;
    logic [31:0] pc_plus_one, PC;
    logic        mem_read, mem_write, mem_push, mem_pop, pc_choose_memory;
    logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
    logic        reg_write, outport_enable;
    logic [2:0]  reg_write_address;
    logic        stall_out, reg_write_out, outport_enable_out, pc_load_out;
    logic [15:0] mem_data_out, result_out, LDM_value_out;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out;
    logic [31:0] new_pc_out;
    logic [10:0] sp_out;
`ifdef STACK_GUARD_EN
    logic        stack_fault_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_new_pc;
    exp_t sb[$];
    vec_t vt[11];

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(11), .SP_INIT(SP_INIT_DEF)) dut (
        .clk(clk), .reset(reset), .result(result), .read_data1(read_data1),
        .read_data2(read_data2), .pc_plus_one(pc_plus_one), .PC(PC), .LDM_value(LDM_value),
        .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .pc_choose_memory(pc_choose_memory), .reg_write(reg_write), .wb_sel(wb_sel),
        .reg_write_address(reg_write_address), .outport_enable(outport_enable),
        .stall_out(stall_out), .mem_data_out(mem_data_out), .result_out(result_out),
        .LDM_value_out(LDM_value_out), .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out),
        .reg_write_address_out(reg_write_address_out), .outport_enable_out(outport_enable_out),
        .new_pc_out(new_pc_out), .pc_load_out(pc_load_out),
`ifdef STACK_GUARD_EN
        .stack_fault_out(stack_fault_out),
`endif
        .sp_out(sp_out)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        result = '0; read_data1 = '0; read_data2 = '0; LDM_value = '0;
        pc_plus_one = '0; PC = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_push = 1'b0; mem_pop = 1'b0;
        pc_choose_memory = 1'b0; memory_address_select = 2'b00; memory_write_src_select = 2'b00;
        reg_write = 1'b0; wb_sel = 2'b00; reg_write_address = 3'd0; outport_enable = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] data, input logic [10:0] sp,
                            input logic bubble, input logic pcl);
        exp_t e;
        e.data = data; e.sp = sp; e.res = result; e.ldm = LDM_value;
        e.rw = bubble ? 1'b0 : reg_write;
        e.op = bubble ? 1'b0 : outport_enable;
        e.wb = wb_sel; e.rwa = reg_write_address;
        e.pc_load = pcl; e.new_pc = exp_new_pc;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
            return;
        end
        e = sb.pop_front();
        check("mem_data_out", 32'(mem_data_out), 32'(e.data));
        check("sp_out", 32'(sp_out), 32'(e.sp));
        check("result_out", 32'(result_out), 32'(e.res));
        check("LDM_value_out", 32'(LDM_value_out), 32'(e.ldm));
        check("reg_write_out", 32'(reg_write_out), 32'(e.rw));
        check("outport_enable_out", 32'(outport_enable_out), 32'(e.op));
        check("wb_sel_out", 32'(wb_sel_out), 32'(e.wb));
        check("reg_write_address_out", 32'(reg_write_address_out), 32'(e.rwa));
        check("pc_load_out", 32'(pc_load_out), 32'(e.pc_load));
        check("new_pc_out", new_pc_out, e.new_pc);
    endtask

    task automatic check_reset_state();
        check("rst_mem_data", 32'(mem_data_out), 32'h0);
        check("rst_result", 32'(result_out), 32'h0);
        check("rst_ldm", 32'(LDM_value_out), 32'h0);
        check("rst_reg_write", 32'(reg_write_out), 32'h0);
        check("rst_wb_sel", 32'(wb_sel_out), 32'h0);
        check("rst_rwa", 32'(reg_write_address_out), 32'h0);
        check("rst_outport", 32'(outport_enable_out), 32'h0);
        check("rst_new_pc", new_pc_out, 32'h0);
        check("rst_pc_load", 32'(pc_load_out), 32'h0);
        check("rst_sp", 32'(sp_out), 32'd2047);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //        res       rd1       rd2       rd wr pu po asel   wsrc   rw  e_data    e_sp
        vt[0]  = '{16'h0010, 16'hBEEF, 16'h0000, 0, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0000, 11'd2047};
        vt[1]  = '{16'h0010, 16'h0000, 16'h0000, 1, 0, 0, 0, 2'b00, 2'b00, 1, 16'hBEEF, 11'd2047};
        vt[2]  = '{16'h0020, 16'h1111, 16'h0000, 1, 1, 0, 0, 2'b00, 2'b00, 0, 16'h0000, 11'd2047};
        vt[3]  = '{16'h0020, 16'h0000, 16'h0000, 1, 0, 0, 0, 2'b00, 2'b00, 1, 16'h1111, 11'd2047};
        vt[4]  = '{16'h0000, 16'h1234, 16'h0000, 0, 0, 1, 0, 2'b01, 2'b00, 0, 16'h0000, 11'd2046};
        vt[5]  = '{16'h0000, 16'h5555, 16'h0000, 0, 0, 1, 1, 2'b01, 2'b00, 1, 16'h0000, 11'd2046};
        vt[6]  = '{16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 2'b01, 2'b00, 1, 16'h1234, 11'd2047};
        vt[7]  = '{16'h0010, 16'h0000, 16'h0000, 1, 0, 0, 0, 2'b11, 2'b00, 0, 16'hBEEF, 11'd2047};
        vt[8]  = '{16'h0000, 16'h0020, 16'h0000, 1, 0, 0, 0, 2'b10, 2'b00, 1, 16'h1111, 11'd2047};
        vt[9]  = '{16'h0030, 16'h0000, 16'hCAFE, 0, 1, 0, 0, 2'b00, 2'b01, 0, 16'h0000, 11'd2047};
        vt[10] = '{16'h0030, 16'h0000, 16'h0000, 1, 0, 0, 0, 2'b00, 2'b00, 1, 16'hCAFE, 11'd2047};

        idle_inputs();
        exp_new_pc = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        check("rst_stall", 32'(stall_out), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            idle_inputs();
            result = vt[i].res; read_data1 = vt[i].rd1; read_data2 = vt[i].rd2;
            mem_read = vt[i].rd; mem_write = vt[i].wr;
            mem_push = vt[i].push; mem_pop = vt[i].pop;
            memory_address_select = vt[i].asel; memory_write_src_select = vt[i].wsrc;
            reg_write = vt[i].rw; wb_sel = 2'(i); reg_write_address = 3'(i);
            outport_enable = i[0]; LDM_value = 16'h0100 + 16'(i);
            #1;
            check("row_stall", 32'(stall_out), 32'h0);
            push_exp(vt[i].e_data, vt[i].e_sp, 1'b0, 1'b0);
            tick();
        end

        // CALL: 32-bit push of pc_plus_one
        idle_inputs();
        mem_push = 1'b1; memory_address_select = 2'b01; memory_write_src_select = 2'b10;
        pc_plus_one = 32'h0001_0042; PC = 32'h0000_1234;
        reg_write = 1'b1; outport_enable = 1'b1; wb_sel = 2'b01; reg_write_address = 3'd2;
        #1;
        check("call_stall_c1", 32'(stall_out), 32'h1);
        push_exp(16'h0000, 11'd2046, 1'b1, 1'b0);
        tick();
        check("call_stall_c2", 32'(stall_out), 32'h0);
        push_exp(16'h0000, 11'd2045, 1'b0, 1'b0);
        tick();
        idle_inputs();
        mem_read = 1'b1; result = 16'd2047;
        #1;
        check("after_call_stall", 32'(stall_out), 32'h0);
        push_exp(16'h0001, 11'd2045, 1'b0, 1'b0);
        tick();
        result = 16'd2046;
        push_exp(16'h0042, 11'd2045, 1'b0, 1'b0);
        tick();

        // RET: 32-bit pop into new_pc_out
        idle_inputs();
        mem_pop = 1'b1; memory_address_select = 2'b01; pc_choose_memory = 1'b1;
        reg_write = 1'b1; outport_enable = 1'b1;
        #1;
        check("ret_stall_c1", 32'(stall_out), 32'h1);
        push_exp(16'h0042, 11'd2046, 1'b1, 1'b0);
        tick();
        check("ret_stall_c2", 32'(stall_out), 32'h0);
        exp_new_pc = 32'h0001_0042;
        push_exp(16'h0001, 11'd2047, 1'b0, 1'b1);
        tick();
        idle_inputs();
        push_exp(16'h0000, 11'd2047, 1'b0, 1'b0);
        tick();

        // Reset while in WORD2 of a 32-bit PC push
        idle_inputs();
        mem_push = 1'b1; memory_address_select = 2'b01; memory_write_src_select = 2'b11;
        PC = 32'h0005_0077; pc_plus_one = 32'h0009_0099; reg_write = 1'b1;
        #1;
        check("int_stall_c1", 32'(stall_out), 32'h1);
        push_exp(16'h0000, 11'd2046, 1'b1, 1'b0);
        tick();
        reset = 1'b0;
        exp_new_pc = '0;
        #1;
        check_reset_state();
        idle_inputs();
        @(posedge clk);
        #1;
        check_reset_state();
        check("rst_mid_stall", 32'(stall_out), 32'h0);
        reset = 1'b1;
        mem_read = 1'b1; result = 16'd2046;
        push_exp(16'h0042, 11'd2047, 1'b0, 1'b0);
        tick();
        result = 16'd2047;
        push_exp(16'h0005, 11'd2047, 1'b0, 1'b0);
        tick();

`ifdef STACK_GUARD_EN
        check("fault_initial", 32'(stack_fault_out), 32'h0);
        idle_inputs();
        mem_pop = 1'b1; memory_address_select = 2'b01; reg_write = 1'b1; outport_enable = 1'b1;
        #1;
        check("guard_stall", 32'(stall_out), 32'h0);
        push_exp(16'h0000, 11'd2047, 1'b1, 1'b0);
        tick();
        check("fault_set", 32'(stack_fault_out), 32'h1);
        idle_inputs();
        push_exp(16'h0000, 11'd2047, 1'b0, 1'b0);
        tick();
        check("fault_sticky", 32'(stack_fault_out), 32'h1);
`endif

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: %0d entries left over", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
